// File: rtl/micro_tile_sequencer.sv
// Sequences clock enable and reset across four micro-tiles: OFF -> HOLD -> RUN -> STOP -> GAP -> HOLD.
// Define MICRO_TILE_AUTO_SCAN_EN to enable timed round-robin rotation while scan_en is high.
module micro_tile_sequencer #(
  parameter int NUM_TILES   = 4,
  parameter int RST_HOLD    = 4,
  parameter int SCAN_PERIOD = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [1:0]           req_sel,
  output logic                 req_ready,
  input  logic                 scan_en,
  output logic [1:0]           tile_sel,
  output logic [NUM_TILES-1:0] tile_clk_en,
  output logic [NUM_TILES-1:0] tile_rst_n,
  output logic                 busy
);

  typedef enum logic [2:0] {OFF, HOLD, RUN, STOP, GAP} state_e;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);

  state_e                 state_q;
  logic [1:0]             tile_sel_q;
  logic [1:0]             pend_sel_q;
  logic [NUM_TILES-1:0]   clk_en_q;
  logic [NUM_TILES-1:0]   rst_n_q;
  logic                   ready_q;
  logic                   busy_q;
  logic [7:0]             hold_cnt_q;

  logic                   host_acc;
  logic                   scan_hit;
  logic [1:0]             next_sel_d;

  function automatic logic [NUM_TILES-1:0] one_hot(input logic [1:0] idx);
    one_hot      = '0;
    one_hot[idx] = 1'b1;
  endfunction

  assign host_acc = req_valid & ready_q;

`ifdef MICRO_TILE_AUTO_SCAN_EN
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_PERIOD - 1);
  logic [15:0] scan_cnt_q;
  assign scan_hit = (state_q == RUN) && scan_en && (scan_cnt_q == SCAN_LAST);
`else
  logic scan_unused;
  assign scan_unused = scan_en;
  assign scan_hit    = 1'b0;
`endif

  // A host request always beats the internal rotation request.
  assign next_sel_d = host_acc ? req_sel : (tile_sel_q + 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      tile_sel_q <= '0;
      pend_sel_q <= '0;
      clk_en_q   <= '0;
      rst_n_q    <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        OFF: begin
          if (host_acc) begin
            state_q    <= HOLD;
            tile_sel_q <= req_sel;
            clk_en_q   <= one_hot(req_sel);
            rst_n_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            hold_cnt_q <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (hold_cnt_q == 8'd0) begin
            state_q <= RUN;
            rst_n_q <= clk_en_q;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end
        end
        RUN: begin
          if (host_acc || scan_hit) begin
            state_q    <= STOP;
            pend_sel_q <= next_sel_d;
            rst_n_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        STOP: begin
          state_q  <= GAP;
          clk_en_q <= '0;
        end
        GAP: begin
          state_q    <= HOLD;
          tile_sel_q <= pend_sel_q;
          clk_en_q   <= one_hot(pend_sel_q);
          hold_cnt_q <= HOLD_INIT;
        end
        default: begin
          state_q  <= OFF;
          clk_en_q <= '0;
          rst_n_q  <= '0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MICRO_TILE_AUTO_SCAN_EN
  // Counts dwell cycles in RUN; any exit from RUN or scan_en low restarts the dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
    end else if (state_q != RUN || !scan_en || host_acc || scan_hit) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + 16'd1;
    end
  end
`endif

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign tile_sel    = tile_sel_q;
  assign tile_clk_en = clk_en_q;
  assign tile_rst_n  = rst_n_q;

endmodule

// File: tb/tb_micro_tile_sequencer.sv
// Directed bench for micro_tile_sequencer (RST_HOLD=4, SCAN_PERIOD=8) with a per-cycle invariant monitor.
module tb_micro_tile_sequencer;

  localparam int RST_HOLD    = 4;
  localparam int SCAN_PERIOD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqValid;
  logic [1:0] reqSel;
  logic       reqReady;
  logic       scanEn;
  logic [1:0] tileSel;
  logic [3:0] tileClkEn;
  logic [3:0] tileRstN;
  logic       busy;
  logic       monitorOn = 1'b0;

  int testCount = 0;
  int failCount = 0;

  micro_tile_sequencer #(
    .NUM_TILES(4), .RST_HOLD(RST_HOLD), .SCAN_PERIOD(SCAN_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_sel(reqSel),
    .req_ready(reqReady), .scan_en(scanEn), .tile_sel(tileSel),
    .tile_clk_en(tileClkEn), .tile_rst_n(tileRstN), .busy(busy)
  );

  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task applyStimulus(input logic valid, input logic [1:0] sel);
    reqValid = valid;
    reqSel   = sel;
  endtask

  task waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] oneHot(input logic [1:0] idx);
    oneHot = 4'b0001 << idx;
  endfunction

  task checkReset(input string tag);
    checkOutput({tag, " sel"},   32'(tileSel),   32'd0);
    checkOutput({tag, " clken"}, 32'(tileClkEn), 32'd0);
    checkOutput({tag, " rstn"},  32'(tileRstN),  32'd0);
    checkOutput({tag, " ready"}, 32'(reqReady),  32'd1);
    checkOutput({tag, " busy"},  32'(busy),      32'd0);
  endtask

  // One rotation step: starts on the first RUN cycle of cur and ends on the first RUN cycle of nxt.
  task scanHop(input logic [1:0] cur, input logic [1:0] nxt);
    checkOutput("scan run rstn", 32'(tileRstN), 32'(oneHot(cur)));
    waitCycles(SCAN_PERIOD - 1);
    checkOutput("scan dwell ready", 32'(reqReady), 32'd1);
    waitCycles(1);
    checkOutput("scan stop busy", 32'(busy), 32'd1);
    checkOutput("scan stop rstn", 32'(tileRstN), 32'd0);
    waitCycles(2);
    checkOutput("scan hold sel", 32'(tileSel), 32'(nxt));
    waitCycles(RST_HOLD);
    checkOutput("scan release rstn", 32'(tileRstN), 32'(oneHot(nxt)));
  endtask

  always @(negedge clk) begin
    logic ok;
    if (monitorOn) begin
      ok = ($countones(tileClkEn) <= 1) && (busy == !reqReady);
      for (int i = 0; i < 4; i++)
        if (tileRstN[i] && !(tileClkEn[i] && tileSel == 2'(i))) ok = 1'b0;
      checkOutput("invariant", 32'(ok), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0);
`ifdef MICRO_TILE_AUTO_SCAN_EN
    scanEn = 1'b0;
`else
    scanEn = 1'b1;
`endif
    waitCycles(2);
    monitorOn = 1'b1;
    checkReset("reset");
    rst = 1'b0;

    // Start tile 2 from OFF.
    applyStimulus(1'b1, 2'd2);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    for (int k = 1; k <= RST_HOLD; k++) begin
      checkOutput("off hold sel",   32'(tileSel),   32'd2);
      checkOutput("off hold clken", 32'(tileClkEn), 32'b0100);
      checkOutput("off hold rstn",  32'(tileRstN),  32'd0);
      checkOutput("off hold busy",  32'(busy),      32'd1);
      waitCycles(1);
    end
    checkOutput("off release rstn",  32'(tileRstN), 32'b0100);
    checkOutput("off release ready", 32'(reqReady), 32'd1);

    // Switch from tile 2 to tile 1.
    applyStimulus(1'b1, 2'd1);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("stop rstn",  32'(tileRstN),  32'd0);
    checkOutput("stop clken", 32'(tileClkEn), 32'b0100);
    waitCycles(1);
    checkOutput("gap clken", 32'(tileClkEn), 32'd0);
    checkOutput("gap sel",   32'(tileSel),   32'd2);
    waitCycles(1);
    checkOutput("switch sel",   32'(tileSel),   32'd1);
    checkOutput("switch clken", 32'(tileClkEn), 32'b0010);
    waitCycles(RST_HOLD - 1);
    checkOutput("switch early rstn", 32'(tileRstN), 32'd0);
    waitCycles(1);
    checkOutput("switch release rstn", 32'(tileRstN), 32'b0010);

    // Switch to tile 0 while a tile 3 request is held through STOP/GAP/HOLD.
    applyStimulus(1'b1, 2'd0);
    waitCycles(1);
    applyStimulus(1'b1, 2'd3);
    waitCycles(3);
    applyStimulus(1'b0, 2'd0);
    checkOutput("ignore hold sel", 32'(tileSel), 32'd0);
    waitCycles(RST_HOLD - 1);
    checkOutput("ignore release rstn", 32'(tileRstN), 32'b0001);
    waitCycles(20);
    checkOutput("ignore later sel",   32'(tileSel),  32'd0);
    checkOutput("ignore later rstn",  32'(tileRstN), 32'b0001);
    checkOutput("ignore later ready", 32'(reqReady), 32'd1);

`ifndef MICRO_TILE_AUTO_SCAN_EN
    waitCycles(4 * SCAN_PERIOD);
    checkOutput("noscan held sel",  32'(tileSel),  32'd0);
    checkOutput("noscan held rstn", 32'(tileRstN), 32'b0001);
`endif

    // Restart of the running tile goes through the full sequence.
    applyStimulus(1'b1, 2'd0);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("restart stop rstn", 32'(tileRstN), 32'd0);
    checkOutput("restart stop busy", 32'(busy),     32'd1);
    waitCycles(1);
    checkOutput("restart gap clken", 32'(tileClkEn), 32'd0);
    waitCycles(1);
    checkOutput("restart hold clken", 32'(tileClkEn), 32'b0001);
    waitCycles(RST_HOLD);
    checkOutput("restart release rstn", 32'(tileRstN), 32'b0001);

    // Reset during GAP, with a request presented alongside it.
    applyStimulus(1'b1, 2'd3);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    waitCycles(1);
    checkOutput("pre-rst gap clken", 32'(tileClkEn), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd1);
    waitCycles(1);
    checkReset("rst gap");
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0);
    waitCycles(1);
    checkReset("rst discard");

    // Reset during HOLD.
    applyStimulus(1'b1, 2'd3);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("pre-rst hold sel", 32'(tileSel), 32'd3);
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);
    checkReset("rst hold");
    rst = 1'b0;

`ifdef MICRO_TILE_AUTO_SCAN_EN
    scanEn = 1'b1;
    applyStimulus(1'b1, 2'd3);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    waitCycles(RST_HOLD);
    scanHop(2'd3, 2'd0);
    scanHop(2'd0, 2'd1);
    scanHop(2'd1, 2'd2);
    // Host restart of tile 2 collides with the internal request for tile 3.
    waitCycles(SCAN_PERIOD - 1);
    applyStimulus(1'b1, 2'd2);
    waitCycles(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("host win stop busy", 32'(busy), 32'd1);
    waitCycles(2);
    checkOutput("host win sel",   32'(tileSel),   32'd2);
    checkOutput("host win clken", 32'(tileClkEn), 32'b0100);
    waitCycles(RST_HOLD);
    checkOutput("host win rstn", 32'(tileRstN), 32'b0100);
`endif

    monitorOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/micro_tile_sequencer.md
MICRO_TILE_SEQUENCER -- requirements
Module: micro_tile_sequencer

Interface
REQ-001 SHALL have parameter NUM_TILES, default 4: number of micro-tiles sequenced; fixed at 4 in this release.
REQ-002 SHALL have parameter RST_HOLD, default 4, legal range 1..255: cycles a newly selected tile is held in reset with its clock running.
REQ-003 SHALL have parameter SCAN_PERIOD, default 1024, legal range 2..65535: dwell cycles per tile in auto-scan.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1: host requests a switch to req_sel.
REQ-007 SHALL have port req_sel, input, 2: target tile index.
REQ-008 SHALL have port req_ready, output, 1: sequencer can accept a request this cycle.
REQ-009 SHALL have port scan_en, input, 1: auto-scan enable; present in every build.
REQ-010 SHALL have port tile_sel, output, 2: tile index driving the output mux.
REQ-011 SHALL have port tile_clk_en, output, 4: one-hot-or-zero clock enable per tile.
REQ-012 SHALL have port tile_rst_n, output, 4: active-low reset per tile.
REQ-013 SHALL have port busy, output, 1: a switch sequence is in progress.

Function
REQ-014 SHALL implement states OFF, HOLD, RUN, STOP, GAP; all outputs SHALL be registered.
REQ-015 SHALL accept a request only in the cycle where req_valid and req_ready are both 1; req_valid while req_ready=0 SHALL be ignored, not queued.
REQ-016 SHALL drive req_ready=1 only in OFF and RUN, and busy = NOT req_ready.
REQ-017 OFF, request accepted at edge T: from T+1 state HOLD, tile_sel=req_sel, tile_clk_en=one-hot(req_sel), tile_rst_n all 0.
REQ-018 HOLD SHALL last exactly RST_HOLD cycles, then RUN with tile_rst_n[tile_sel]=1, all other bits 0.
REQ-019 RUN, request accepted at edge T: T+1 STOP (tile_rst_n all 0, tile_clk_en unchanged); T+2 GAP (tile_clk_en all 0, tile_sel unchanged); T+3 HOLD with new tile_sel and clk_en.
REQ-020 A request for the currently running tile SHALL execute the full STOP/GAP/HOLD sequence (tile restart).
REQ-021 tile_clk_en SHALL never have more than one bit set; tile_rst_n[i]=1 SHALL imply tile_clk_en[i]=1 and tile_sel=i.
REQ-022 tile_sel SHALL change only on the GAP->HOLD or OFF->HOLD transition.
REQ-023 Latency request-accept to tile_rst_n release: 1+RST_HOLD cycles from OFF; 3+RST_HOLD cycles from RUN.

Reset
REQ-024 When rst=1 at a clock edge, the next state SHALL be OFF with tile_sel=0, tile_clk_en=0, tile_rst_n=0, req_ready=1, busy=0, scan counter 0, regardless of current state.
REQ-025 A request presented in the same cycle as rst=1 SHALL be discarded.

Configuration
REQ-026 With macro MICRO_TILE_AUTO_SCAN_EN defined: in RUN with scan_en=1, a counter SHALL count RUN cycles and after SCAN_PERIOD cycles internally request tile (tile_sel+1) mod 4 via the REQ-019 sequence.
REQ-027 With the macro defined: a host request in the same cycle as the internal request SHALL win; the counter SHALL clear on every entry to RUN and while scan_en=0.
REQ-028 Without the macro: no counter SHALL be synthesised; scan_en SHALL be ignored; the port list SHALL be identical.

Verification (RST_HOLD=4, SCAN_PERIOD=8)
REQ-029 Reset, req_valid=1 req_sel=2 at T -> T+1..T+4 tile_sel=2, clk_en=0100, rst_n=0000, busy=1; T+5 rst_n=0100, req_ready=1.
REQ-030 RUN tile 2, request tile 1 at T -> T+1 rst_n=0000 clk_en=0100; T+2 clk_en=0000 tile_sel=2; T+3 tile_sel=1 clk_en=0010; T+7 rst_n=0010.
REQ-031 req_valid pulsed for tile 3 during HOLD -> ignored; tile stays at previous target, no later switch.
REQ-032 rst=1 in GAP and in HOLD -> next cycle all outputs at REQ-024 values.
REQ-033 Macro defined, scan_en=1, RUN tile 3 -> after 8 RUN cycles STOP begins, rotation reaches tile 0, then 1; simultaneous host request for tile 2 wins.
REQ-034 Assertions every cycle: REQ-021 invariants; macro undefined, scan_en=1 -> RUN held indefinitely.
